dual_slope_sequencer: RTL and testbench

//   Conversion-cycle controller for the MC14433-style dual-slope ADC model. Free-running

---
 rtl/dual_slope_sequencer.sv | 119 +++++++++++
 tb/tb_dual_slope_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dual_slope_sequencer.sv
// Conversion-cycle controller for a dual-slope ADC:
// auto-zero, signal integrate, reference de-integrate, latch.
module dual_slope_sequencer #(
  parameter int W         = 12,
  parameter int AZ_CNT    = 4000,
  parameter int INT_CNT   = 4000,
  parameter int DEINT_MAX = 4000,
  parameter int FS_CNT    = 1999,
  parameter int UR_CNT    = 180
) (
  input  logic         CP0,
  input  logic         R_clock,
  input  logic         D,
  input  logic         POL_IN,
  input  logic         DU,
  output logic         AZ,
  output logic         INT_EN,
  output logic         DEINT_EN,
  output logic [W-1:0] RESULT,
  output logic         POL,
  output logic         OVR,
  output logic         UNR,
  output logic         EOC
);

  typedef enum logic [1:0] {
    S_AZ,
    S_INT,
    S_DEINT,
    S_LATCH
  } state_t;

  localparam logic [W-1:0] AZ_LAST  = W'(AZ_CNT - 1);
  localparam logic [W-1:0] INT_LAST = W'(INT_CNT - 1);
  localparam logic [W-1:0] DM_LAST  = W'(DEINT_MAX - 1);
  localparam logic [W-1:0] FS_V     = W'(FS_CNT);
  localparam logic [W-1:0] UR_V     = W'(UR_CNT);

  state_t       state;
  logic [W-1:0] cnt;
  logic         pol_tmp;
  logic         timeout;

  always_ff @(posedge CP0 or posedge R_clock) begin
    if (R_clock) begin
      state    <= S_AZ;
      cnt      <= '0;
      pol_tmp  <= 1'b0;
      timeout  <= 1'b0;
      AZ       <= 1'b1;
      INT_EN   <= 1'b0;
      DEINT_EN <= 1'b0;
      EOC      <= 1'b0;
      RESULT   <= '0;
      POL      <= 1'b0;
      OVR      <= 1'b0;
      UNR      <= 1'b0;
    end else begin
      unique case (state)
        S_AZ: begin
          if (cnt == AZ_LAST) begin
            state  <= S_INT;
            cnt    <= '0;
            AZ     <= 1'b0;
            INT_EN <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INT: begin
          if (cnt == INT_LAST) begin
            pol_tmp  <= POL_IN;
            state    <= S_DEINT;
            cnt      <= '0;
            INT_EN   <= 1'b0;
            DEINT_EN <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DEINT: begin
          // cnt stays frozen through S_LATCH as the conversion count
          if (!D) begin
            state    <= S_LATCH;
            timeout  <= 1'b0;
            DEINT_EN <= 1'b0;
            EOC      <= 1'b1;
          end else if (cnt == DM_LAST) begin
            state    <= S_LATCH;
            cnt      <= cnt + 1'b1;
            timeout  <= 1'b1;
            DEINT_EN <= 1'b0;
            EOC      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (DU) begin
            RESULT <= cnt;
            POL    <= pol_tmp;
            OVR    <= (cnt > FS_V) | timeout;
            UNR    <= (cnt < UR_V);
          end
          state <= S_AZ;
          cnt   <= '0;
          EOC   <= 1'b0;
          AZ    <= 1'b1;
        end
        default: begin
          state <= S_AZ;
          cnt   <= '0;
          AZ    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Self-checking bench: table of conversions with scoreboard,
// plus a mid-de-integrate reset sequence.
module tb_dual_slope_sequencer;

  logic       CP0;
  logic       R_clock;
  logic       D;
  logic       POL_IN;
  logic       DU;
  logic       AZ;
  logic       INT_EN;
  logic       DEINT_EN;
  logic [4:0] RESULT;
  logic       POL;
  logic       OVR;
  logic       UNR;
  logic       EOC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pol;
    int         nd;
    logic       du;
    logic [4:0] res;
    logic       epol;
    logic       eovr;
    logic       eunr;
  } vec_t;

  typedef struct {
    logic [4:0] res;
    logic       pol;
    logic       ovr;
    logic       unr;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  dual_slope_sequencer #(
    .W(5), .AZ_CNT(4), .INT_CNT(8), .DEINT_MAX(16),
    .FS_CNT(9), .UR_CNT(2)
  ) dut (
    .CP0(CP0), .R_clock(R_clock), .D(D), .POL_IN(POL_IN),
    .DU(DU), .AZ(AZ), .INT_EN(INT_EN), .DEINT_EN(DEINT_EN),
    .RESULT(RESULT), .POL(POL), .OVR(OVR), .UNR(UNR),
    .EOC(EOC)
  );

  initial CP0 = 1'b0;
  always #5 CP0 = ~CP0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_az_int(input logic pol);
    int n;
    n = 0;
    while (AZ && n < 50) begin
      D = 1'($urandom);
      POL_IN = !pol;
      @(negedge CP0);
      n++;
    end
    chk("az_len", n, 4);
    n = 0;
    while (INT_EN && n < 50) begin
      D = 1'($urandom);
      POL_IN = (n == 7) ? pol : !pol;
      @(negedge CP0);
      n++;
    end
    chk("int_len", n, 8);
    chk("deint_start", int'(DEINT_EN), 1);
  endtask

  task automatic do_deint(input int nd, output int n);
    n = 0;
    while (DEINT_EN && n < 50) begin
      D = (n < nd);
      chk("onehot_deint", int'({AZ, INT_EN, EOC}), 0);
      @(negedge CP0);
      n++;
    end
  endtask

  task automatic latch_check();
    exp_t e;
    chk("eoc_hi", int'(EOC), 1);
    chk("latch_en_low", int'({AZ, INT_EN, DEINT_EN}), 0);
    D = 1'b1;
    @(negedge CP0);
    chk("eoc_lo", int'(EOC), 0);
    chk("az_after_eoc", int'(AZ), 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("result", int'(RESULT), int'(e.res));
      chk("pol", int'(POL), int'(e.pol));
      chk("ovr", int'(OVR), int'(e.ovr));
      chk("unr", int'(UNR), int'(e.unr));
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    e.res = v.res;
    e.pol = v.epol;
    e.ovr = v.eovr;
    e.unr = v.eunr;
    sb.push_back(e);
    DU = v.du;
    do_az_int(v.pol);
    do_deint(v.nd, n);
    chk("deint_len", n, (v.nd >= 16) ? 16 : v.nd + 1);
    latch_check();
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{1'b1, 6,   1'b1, 5'd6,  1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 100, 1'b1, 5'd16, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 12,  1'b1, 5'd12, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 0,   1'b1, 5'd0,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 9,   1'b1, 5'd9,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 10,  1'b1, 5'd10, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1,   1'b1, 5'd1,  1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 2,   1'b1, 5'd2,  1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 15,  1'b0, 5'd2,  1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 15,  1'b1, 5'd15, 1'b1, 1'b1, 1'b0};

    R_clock = 1'b1;
    D = 1'b0;
    POL_IN = 1'b0;
    DU = 1'b1;
    repeat (3) @(negedge CP0);
    chk("rst_az", int'(AZ), 1);
    chk("rst_en", int'({INT_EN, DEINT_EN, EOC}), 0);
    chk("rst_res", int'(RESULT), 0);
    chk("rst_flags", int'({POL, OVR, UNR}), 0);
    R_clock = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset in the middle of de-integration
    DU = 1'b1;
    do_az_int(1'b1);
    D = 1'b1;
    repeat (3) @(negedge CP0);
    R_clock = 1'b1;
    #1;
    chk("mid_rst_az", int'(AZ), 1);
    chk("mid_rst_deint", int'(DEINT_EN), 0);
    chk("mid_rst_res", int'(RESULT), 0);
    chk("mid_rst_flags", int'({POL, OVR, UNR, EOC}), 0);
    @(negedge CP0);
    chk("mid_rst_eoc", int'(EOC), 0);
    R_clock = 1'b0;
    rv = '{1'b1, 4, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0};
    run_vec(rv);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
